instr_mem_loader: RTL and testbench

//  Writer side of the instruction-memory load port: takes a byte stream (valid/ready) from a host/boot link,

---
 rtl/instr_mem_loader_pkg.sv | 13 +
 rtl/instr_mem_loader_word_assembler.sv | 39 +++
 rtl/instr_mem_loader.sv | 92 +++++++++
 tb/tb_instr_mem_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared state encodings and widths for the instruction-memory loader
package instr_mem_loader_pkg;
    localparam int INSTR_WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam logic [2:0] LDR_IDLE   = 3'd0;
    localparam logic [2:0] LDR_LEN_HI = 3'd1;
    localparam logic [2:0] LDR_LEN_LO = 3'd2;
    localparam logic [2:0] LDR_DATA   = 3'd3;
    localparam logic [2:0] LDR_WRITE  = 3'd4;
    localparam logic [2:0] LDR_CHK    = 3'd5;
    localparam logic [2:0] LDR_DONE   = 3'd6;
    localparam logic [2:0] LDR_ERR    = 3'd7;
endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// loader_word_assembler: pairs big-endian data bytes into 16-bit words; INSTR_LOADER_CHECKSUM_EN adds an XOR accumulator
module loader_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    byte_en,
    input  logic [BYTE_W-1:0]       byte_in,
    output logic [INSTR_WORD_W-1:0] word,
    output logic                    word_valid,
`ifdef INSTR_LOADER_CHECKSUM_EN
    output logic [BYTE_W-1:0]       xor_acc,
`endif
    output logic                    phase
);
    logic [BYTE_W-1:0] hi;
    // phase 0 expects the HI byte, phase 1 the LO byte; word_valid pulses the cycle after LO is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            word <= '0;
            word_valid <= 1'b0;
            phase <= 1'b0;
        end else begin
            word_valid <= byte_en && phase;
            phase <= clear ? 1'b0 : byte_en ? ~phase : phase;
            if (byte_en && phase) word <= {hi, byte_in};
            if (byte_en && !phase) hi <= byte_in;
        end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    // running XOR of every data byte of the session
    always_ff @(posedge clk) begin
        if (rst || clear) xor_acc <= '0;
        else if (byte_en) xor_acc <= xor_acc ^ byte_in;
    end
`endif
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream to instruction-memory writer; define INSTR_LOADER_CHECKSUM_EN for a trailing XOR check byte
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int          N         = 6,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [BYTE_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    write_enable,
    output logic [31:0]             write_addr,
    output logic [INSTR_WORD_W-1:0] write_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam logic [16:0] MAX_LEN = 17'(2 ** N);
    logic [2:0] state;
    logic [BYTE_W-1:0] len_hi;
    logic [15:0] remaining;
    logic [31:0] addr;
    logic [16:0] len;
    logic accept, byte_en, phase, idle_like;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_acc;
`endif
    assign in_ready = state inside {LDR_LEN_HI, LDR_LEN_LO, LDR_DATA, LDR_CHK};
    assign busy = state inside {LDR_LEN_HI, LDR_LEN_LO, LDR_DATA, LDR_WRITE, LDR_CHK};
    assign done = state == LDR_DONE;
    assign err = state == LDR_ERR;
    assign idle_like = state inside {LDR_IDLE, LDR_DONE, LDR_ERR};
    assign accept = in_valid && in_ready;
    assign byte_en = accept && state == LDR_DATA;
    assign len = {1'b0, len_hi, in_data};

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start && idle_like),
        .byte_en    (byte_en),
        .byte_in    (in_data),
        .word       (write_data),
        .word_valid (write_enable),
`ifdef INSTR_LOADER_CHECKSUM_EN
        .xor_acc    (xor_acc),
`endif
        .phase      (phase)
    );

    // session FSM with word counter and address counter; write_addr latches alongside the assembled word
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LDR_IDLE;
            len_hi <= '0;
            remaining <= '0;
            addr <= BASE_ADDR;
            write_addr <= '0;
        end else begin
            case (state)
                LDR_IDLE, LDR_DONE, LDR_ERR: if (start) begin
                    state <= LDR_LEN_HI;
                    addr <= BASE_ADDR;
                end
                LDR_LEN_HI: if (accept) begin
                    len_hi <= in_data;
                    state <= LDR_LEN_LO;
                end
                LDR_LEN_LO: if (accept) begin
                    remaining <= len[15:0];
                    state <= len == '0 ? LDR_DONE : len > MAX_LEN ? LDR_ERR : LDR_DATA;
                end
                LDR_DATA: if (accept && phase) begin
                    remaining <= remaining - 16'd1;
                    write_addr <= addr;
                    addr <= addr + 32'd1;
                    state <= LDR_WRITE;
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                LDR_WRITE: state <= remaining != '0 ? LDR_DATA : LDR_CHK;
                LDR_CHK: if (accept) state <= in_data == xor_acc ? LDR_DONE : LDR_ERR;
`else
                LDR_WRITE: state <= remaining != '0 ? LDR_DATA : LDR_DONE;
`endif
                default: state <= LDR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;
    localparam int N = 6;
    localparam logic [31:0] BASE = 32'd0;
    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic in_ready, write_enable, busy, done, err;
    logic [31:0] write_addr;
    logic [15:0] write_data;
    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    logic prev_we = 1'b0;
    wr_t exp_q[$];
    logic [15:0] words[$];

    instr_mem_loader #(.N(N), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // monitor: every write strobe is matched against the next expected write
    always @(negedge clk) begin
        if (!rst && write_enable) begin
            check("we_not_back_to_back", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                check("write_addr", write_addr, exp_q[0].a);
                check("write_data", write_data, exp_q[0].d);
                void'(exp_q.pop_front());
            end
            wr_count <= wr_count + 1;
        end
        prev_we <= write_enable;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    // reference: legal non-empty length writes every word at BASE+k; checksum (if built) decides done/err
    task automatic run_session(input logic [15:0] len, input bit gaps, input bit mid_start, input bit bad_chk);
        logic [7:0] b[$];
        logic [7:0] x = 8'd0;
        bit ok = 1'b1;
        int nwr = 0;
        int wc0;
        int n = 0;
        b.push_back(len[15:8]);
        b.push_back(len[7:0]);
        if (int'(len) > (1 << N)) begin
            ok = 1'b0;
        end else if (len != 16'd0) begin
            for (int k = 0; k < int'(len); k++) begin
                b.push_back(words[k][15:8]);
                b.push_back(words[k][7:0]);
                x = x ^ words[k][15:8] ^ words[k][7:0];
                exp_q.push_back('{a: BASE + 32'(k), d: words[k]});
            end
            nwr = int'(len);
`ifdef INSTR_LOADER_CHECKSUM_EN
            b.push_back(bad_chk ? x ^ 8'($urandom_range(1, 255)) : x);
            ok = !bad_chk;
`endif
        end
        wc0 = wr_count;
        pulse_start();
        for (int i = 0; i < b.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            if (mid_start && i == 2) pulse_start();
            send_byte(b[i]);
        end
        while (!(done || err) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("session_done", done, ok);
        check("session_err", err, !ok);
        check("session_busy", busy, 1'b0);
        check("session_writes", wr_count - wc0, nwr);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic test1_words();
        words = '{16'h4801, 16'h5022, 16'h0000};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_we"}, write_enable, 1'b0);
        check({tag, "_addr"}, write_addr, 32'd0);
        check({tag, "_data"}, write_data, 16'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int wc0;
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        // test 1: three-word stream
        test1_words();
        run_session(16'd3, 1'b0, 1'b0, 1'b0);
        // test 2: zero length
        run_session(16'd0, 1'b0, 1'b0, 1'b0);
        // test 3: oversize length, then stream stalls
        run_session(16'd65, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        repeat (4) begin
            in_data = 8'($urandom);
            @(negedge clk);
            check("ready_low_after_err", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        run_session(16'h0100, 1'b1, 1'b0, 1'b0);
        // test 4: same stream with gaps and an ignored start mid-session
        test1_words();
        run_session(16'd3, 1'b1, 1'b1, 1'b0);
        // full-depth length is legal
        words.delete();
        for (int k = 0; k < (1 << N); k++) words.push_back(16'($urandom));
        run_session(16'(1 << N), 1'b1, 1'b0, 1'b0);
        // test 5: reset after the first word, with start in the same cycle
        test1_words();
        exp_q.push_back('{a: BASE, d: 16'h4801});
        wc0 = wr_count;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h48);
        send_byte(8'h01);
        n = 0;
        while (wr_count == wc0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_word_before_reset", wr_count - wc0, 1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_all_zero("midload_reset");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_session(16'd3, 1'b0, 1'b0, 1'b0);
        // test 6 (checksum builds): good and bad check byte on test-1 stream
        run_session(16'd3, 1'b0, 1'b0, 1'b1);
        // random sessions
        for (int s = 0; s < 6; s++) begin
            int len = $urandom_range(1, 1 << N);
            words.delete();
            for (int k = 0; k < len; k++) words.push_back(16'($urandom));
            run_session(16'(len), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
